// File: rtl/mem_responder.sv
// mem_responder: wait-stated single-port memory slave answering the
// CPU main bus with a four-phase request/ack handshake.
module mem_responder #(
    parameter int WIDTH_MAIN  = 8,
    parameter int WIDTH_AX    = 16,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH_AX-1:0]   addr,
    input  logic [WIDTH_MAIN-1:0] main_in,
    input  logic                  mem_assert_main,
    input  logic                  mem_load_main,
    input  logic                  mem_dir,
    output logic [WIDTH_MAIN-1:0] mem_out,
    output logic                  mem_ack,
    output logic                  busy,
    output logic                  err
);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [WIDTH_AX:0] DEPTH_X = (WIDTH_AX+1)'(MEM_DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [WIDTH_AX-1:0]   addr_q;
    logic [WIDTH_MAIN-1:0] data_q;
    logic                  rd_q;
    logic                  latch, fire, err_d;

    logic [WIDTH_MAIN-1:0] mem [MEM_DEPTH];

    logic                  rd_req, wr_req, strobes_off;
    logic [WIDTH_AX-1:0]   acc_addr;
    logic [WIDTH_MAIN-1:0] acc_data;
    logic                  acc_rd, in_range;
    logic [IW-1:0]         idx;

    assign rd_req      = mem_assert_main && !mem_load_main && mem_dir;
    assign wr_req      = mem_load_main && !mem_assert_main && !mem_dir;
    assign strobes_off = !mem_assert_main && !mem_load_main;

    // Zero-wait accesses complete on the accept edge, before the latch
    assign acc_addr = (state_q == IDLE) ? addr    : addr_q;
    assign acc_data = (state_q == IDLE) ? main_in : data_q;
    assign acc_rd   = (state_q == IDLE) ? mem_dir : rd_q;
    assign in_range = {1'b0, acc_addr} < DEPTH_X;
    assign idx      = acc_addr[IW-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        fire    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    latch = 1'b1;
                    cnt_d = WS;
                    if (WS == 4'd0) begin
                        state_d = ACK;
                        fire    = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (!strobes_off) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                if (strobes_off) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ACK;
                    cnt_d   = 4'd0;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                if (strobes_off) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (fire && !in_range) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
            mem_out <= '0;
            mem_ack <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_ack <= (state_d == ACK);
            err     <= err_d;
            if (latch) begin
                addr_q <= addr;
                data_q <= main_in;
                rd_q   <= mem_dir;
            end
            if (fire && acc_rd) begin
                mem_out <= in_range ? mem[idx] : '1;
            end
        end
    end

    // Storage survives reset; the store is gated so reset blocks it
    always_ff @(posedge clk) begin
        if (fire && !acc_rd && in_range && reset) begin
            mem[idx] <= acc_data;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (2, 0 and 3 wait states)
// checked every cycle against a transaction-level timing model.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        as_s  [3] = '{default: 1'b0};
    logic        ld_s  [3] = '{default: 1'b0};
    logic        dir_s [3] = '{default: 1'b0};
    logic [15:0] addr_s[3] = '{default: 16'h0};
    logic [7:0]  din_s [3] = '{default: 8'h0};
    logic [7:0]  out_o [3];
    logic        ack_o [3];
    logic        busy_o[3];
    logic        err_o [3];

    int vecs  = 0;
    int fails = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(reset), .addr(addr_s[0]), .main_in(din_s[0]),
        .mem_assert_main(as_s[0]), .mem_load_main(ld_s[0]),
        .mem_dir(dir_s[0]), .mem_out(out_o[0]), .mem_ack(ack_o[0]),
        .busy(busy_o[0]), .err(err_o[0]));

    mem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .addr(addr_s[1]), .main_in(din_s[1]),
        .mem_assert_main(as_s[1]), .mem_load_main(ld_s[1]),
        .mem_dir(dir_s[1]), .mem_out(out_o[1]), .mem_ack(ack_o[1]),
        .busy(busy_o[1]), .err(err_o[1]));

    mem_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .addr(addr_s[2]), .main_in(din_s[2]),
        .mem_assert_main(as_s[2]), .mem_load_main(ld_s[2]),
        .mem_dir(dir_s[2]), .mem_out(out_o[2]), .mem_ack(ack_o[2]),
        .busy(busy_o[2]), .err(err_o[2]));

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a request is live from its accept edge; it completes
    // WS edges later unless both strobes drop first.
    int          ws_of [3] = '{2, 0, 3};
    longint      cyc = 0;
    bit          m_act [3] = '{default: 1'b0};
    bit          m_done[3] = '{default: 1'b0};
    longint      m_t0  [3];
    logic [15:0] m_addr[3];
    logic [7:0]  m_data[3];
    bit          m_rd  [3];
    logic [7:0]  mm    [3][256];
    bit          e_ack [3] = '{default: 1'b0};
    bit          e_busy[3] = '{default: 1'b0};
    bit          e_err [3] = '{default: 1'b0};
    logic [7:0]  e_out [3] = '{default: 8'h0};

    task automatic complete(input int k);
        bit inr;
        inr = m_addr[k] < 16'd256;
        m_done[k] = 1'b1;
        e_err[k] = !inr;
        if (m_rd[k]) e_out[k] = inr ? mm[k][m_addr[k][7:0]] : 8'hFF;
        else if (inr) mm[k][m_addr[k][7:0]] = m_data[k];
    endtask

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                m_act[k] = 0; m_done[k] = 0;
                e_ack[k] = 0; e_busy[k] = 0; e_err[k] = 0;
                e_out[k] = 8'h0;
            end else begin
                bit rv, wv, off;
                rv  = as_s[k] && !ld_s[k] && dir_s[k];
                wv  = ld_s[k] && !as_s[k] && !dir_s[k];
                off = !as_s[k] && !ld_s[k];
                e_err[k] = 1'b0;
                if (!m_act[k]) begin
                    if (rv || wv) begin
                        m_act[k] = 1; m_done[k] = 0; m_t0[k] = cyc;
                        m_addr[k] = addr_s[k]; m_data[k] = din_s[k];
                        m_rd[k] = rv;
                        if (ws_of[k] == 0) complete(k);
                    end else if (!off) begin
                        e_err[k] = 1'b1;
                    end
                end else if (!m_done[k]) begin
                    if (off) m_act[k] = 0;
                    else if (cyc - m_t0[k] == longint'(ws_of[k])) complete(k);
                end else if (off) begin
                    m_act[k] = 0; m_done[k] = 0;
                end
                e_ack[k]  = m_act[k] && m_done[k];
                e_busy[k] = m_act[k];
            end
        end
        if (reset) cyc++;
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("d%0d_ack", k), 32'(ack_o[k]), 32'(e_ack[k]));
                chk($sformatf("d%0d_busy", k), 32'(busy_o[k]), 32'(e_busy[k]));
                chk($sformatf("d%0d_err", k), 32'(err_o[k]), 32'(e_err[k]));
                chk($sformatf("d%0d_out", k), 32'(out_o[k]), 32'(e_out[k]));
            end
        end
    end

    task automatic req(input int k, input bit rd, input logic [15:0] a,
                       input logic [7:0] d, input int hold,
                       output int lat, output logic e_at);
        @(negedge clk);
        as_s[k] = rd; ld_s[k] = !rd; dir_s[k] = rd;
        addr_s[k] = a; din_s[k] = d;
        lat = 0; e_at = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack_o[k]) begin
                lat = i; e_at = err_o[k];
                break;
            end
            if (i == 1) begin
                addr_s[k] = ~a; din_s[k] = ~d; dir_s[k] = !rd;
            end
        end
        chk("ack_seen", 32'(lat != 0), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("ack_held", 32'(ack_o[k]), 32'd1);
        end
        as_s[k] = 1'b0; ld_s[k] = 1'b0;
        @(negedge clk);
        chk("ack_release", 32'(ack_o[k]), 32'd0);
    endtask

    int   lat;
    logic ea;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack_o[0]), 32'd0);
        chk("rst_busy", 32'(busy_o[0]), 32'd0);
        chk("rst_out", 32'(out_o[0]), 32'd0);
        reset = 1'b1;
        checking = 1'b1;

        req(0, 1'b0, 16'h0010, 8'h5A, 0, lat, ea);
        chk("ws2_wr_lat", 32'(lat), 32'd3);
        req(0, 1'b1, 16'h0010, 8'h00, 0, lat, ea);
        chk("ws2_rd_lat", 32'(lat), 32'd3);
        chk("ws2_rd_data", 32'(out_o[0]), 32'h5A);
        chk("ws2_rd_noerr", 32'(ea), 32'd0);

        req(1, 1'b0, 16'h0003, 8'hC3, 0, lat, ea);
        chk("ws0_wr_lat", 32'(lat), 32'd1);
        req(1, 1'b1, 16'h0003, 8'h00, 2, lat, ea);
        chk("ws0_rd_lat", 32'(lat), 32'd1);
        chk("ws0_rd_data", 32'(out_o[1]), 32'hC3);

        @(negedge clk);
        as_s[0] = 1'b1; ld_s[0] = 1'b1; dir_s[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("both_err", 32'(err_o[0]), 32'd1);
            chk("both_busy", 32'(busy_o[0]), 32'd0);
            chk("both_ack", 32'(ack_o[0]), 32'd0);
        end
        as_s[0] = 1'b0; ld_s[0] = 1'b0;
        @(negedge clk);
        chk("both_err_end", 32'(err_o[0]), 32'd0);
        as_s[0] = 1'b1; dir_s[0] = 1'b0;
        @(negedge clk);
        chk("dir_err", 32'(err_o[0]), 32'd1);
        as_s[0] = 1'b0;
        @(negedge clk);
        chk("dir_err_end", 32'(err_o[0]), 32'd0);
        req(0, 1'b1, 16'h0010, 8'h00, 0, lat, ea);
        chk("err_keep_data", 32'(out_o[0]), 32'h5A);

        req(0, 1'b0, 16'h0000, 8'h11, 0, lat, ea);
        req(0, 1'b1, 16'h0100, 8'h00, 0, lat, ea);
        chk("oor_rd_ones", 32'(out_o[0]), 32'hFF);
        chk("oor_rd_err", 32'(ea), 32'd1);
        req(0, 1'b0, 16'h0100, 8'h77, 0, lat, ea);
        chk("oor_wr_err", 32'(ea), 32'd1);
        chk("oor_wr_keep_out", 32'(out_o[0]), 32'hFF);
        req(0, 1'b1, 16'h0000, 8'h00, 0, lat, ea);
        chk("oor_wr_dropped", 32'(out_o[0]), 32'h11);

        req(2, 1'b0, 16'h0020, 8'hAB, 0, lat, ea);
        chk("ws3_wr_lat", 32'(lat), 32'd4);
        @(negedge clk);
        ld_s[2] = 1'b1; dir_s[2] = 1'b0;
        addr_s[2] = 16'h0020; din_s[2] = 8'hCD;
        repeat (2) @(negedge clk);
        ld_s[2] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("abort_noack", 32'(ack_o[2]), 32'd0);
        end
        chk("abort_idle", 32'(busy_o[2]), 32'd0);
        req(2, 1'b1, 16'h0020, 8'h00, 0, lat, ea);
        chk("abort_keep", 32'(out_o[2]), 32'hAB);

        req(0, 1'b0, 16'h0030, 8'h99, 0, lat, ea);
        @(negedge clk);
        ld_s[0] = 1'b1; dir_s[0] = 1'b0;
        addr_s[0] = 16'h0030; din_s[0] = 8'h42;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy_o[0]), 32'd0);
        chk("rst_mid_ack", 32'(ack_o[0]), 32'd0);
        chk("rst_mid_err", 32'(err_o[0]), 32'd0);
        chk("rst_mid_out", 32'(out_o[0]), 32'd0);
        ld_s[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req(0, 1'b1, 16'h0030, 8'h00, 0, lat, ea);
        chk("rst_wr_skipped", 32'(out_o[0]), 32'h99);
        chk("rst_next_lat", 32'(lat), 32'd3);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
